// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, parity modes and the parity
// helper used by both the transmitter and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } uart_tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Parity bit for one data byte; PAR_NONE yields 0, which is never sent.
  function automatic logic calc_parity(input logic [7:0] data, input int mode);
    if (mode == PAR_EVEN) begin
      return ^data;
    end else if (mode == PAR_ODD) begin
      return ~^data;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable bit-period down-counter. A load restarts the period at i_div-1;
// o_bit_done is high on the last clk cycle of the current bit period.
// i_div must be non-zero (the caller maps a zero divisor to 1).
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_bit_done
);

  logic [DIV_WIDTH-1:0] r_cnt;

  // Count down to zero, restarting the period whenever a load is requested.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_div - DIV_WIDTH'(1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - DIV_WIDTH'(1);
    end
  end

  assign o_bit_done = (r_cnt == '0);

endmodule

// File: rtl/axis_uart_tx.sv
// AXI-stream byte consumer and UART serializer: start bit, 8 data bits LSB
// first, optional parity, STOP_BITS stop bits. The divisor is captured with
// each accepted byte so mid-frame divisor changes do not disturb the line.
module axis_uart_tx #(
  parameter int DIV_WIDTH = 16,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tkeep,
  input  logic                 s_axis_tlast,
  output logic                 txd,
  output logic                 busy
);

  import uart_pkg::*;

  uart_tx_state_t       r_state;
  uart_tx_state_t       w_next;
  logic [7:0]           r_shift;
  logic                 r_par;
  logic [2:0]           r_bit_idx;
  logic [DIV_WIDTH-1:0] r_div;

  logic                 w_bit_done;
  logic                 w_accept;
  logic                 w_accept_keep;
  logic                 w_last_stop;
  logic                 w_load;
  logic [DIV_WIDTH-1:0] w_new_div;
  logic [DIV_WIDTH-1:0] w_load_div;
  logic                 w_tlast_unused;

  // tlast carries no framing meaning for a byte-oriented UART.
  assign w_tlast_unused = s_axis_tlast;

  assign w_new_div     = (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_accept_keep = w_accept && s_axis_tkeep;
  assign w_last_stop   = (r_state == STOP) && w_bit_done &&
                         (r_bit_idx == 3'(STOP_BITS - 1));

  // Every bit boundary restarts the period; a new frame uses the fresh divisor.
  assign w_load     = w_accept_keep || ((r_state != IDLE) && w_bit_done);
  assign w_load_div = w_accept_keep ? w_new_div : r_div;

  uart_baud_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_gen (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_div      (w_load_div),
    .o_bit_done (w_bit_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: advance on bit boundaries, chain frames from the last stop cycle.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept_keep) w_next = START;
      end
      START: begin
        if (w_bit_done) w_next = DATA;
      end
      DATA: begin
        if (w_bit_done && (r_bit_idx == 3'd7)) begin
          w_next = (PARITY != PAR_NONE) ? PAR : STOP;
        end
      end
      PAR: begin
        if (w_bit_done) w_next = STOP;
      end
      STOP: begin
        if (w_last_stop) w_next = w_accept_keep ? START : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Byte, parity and divisor capture; shift and bit-index bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_bit_idx <= '0;
      r_div     <= DIV_WIDTH'(1);
    end else begin
      if (w_accept_keep) begin
        r_shift <= s_axis_tdata;
        r_par   <= calc_parity(s_axis_tdata, PARITY);
        r_div   <= w_new_div;
      end else if ((r_state == DATA) && w_bit_done) begin
        r_shift <= {1'b0, r_shift[7:1]};
      end
      if (w_next != r_state) begin
        r_bit_idx <= '0;
      end else if (w_bit_done && ((r_state == DATA) || (r_state == STOP))) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  // Outputs decoded from registered state; tready is forced low during reset.
  always_comb begin
    s_axis_tready = 1'b0;
    txd           = 1'b1;
    busy          = 1'b1;
    case (r_state)
      IDLE: begin
        busy          = 1'b0;
        s_axis_tready = !rst;
      end
      START: txd = 1'b0;
      DATA:  txd = r_shift[0];
      PAR:   txd = r_par;
      STOP:  s_axis_tready = w_last_stop && !rst;
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Directed bench for axis_uart_tx. Three instances cover the parity/stop-bit
// variants; expected line activity is pushed to a scoreboard when a byte is
// offered and popped cycle by cycle while the frame is on the line.
module tb_axis_uart_tx;

  typedef struct {
    logic txd;
    logic tready;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] baud_div = 16'd4;
  logic [7:0]  tdata = 8'h00;
  logic        tkeep = 1'b1;
  logic        tlast = 1'b0;
  logic [2:0]  tvalid = 3'b000;
  logic [2:0]  tready;
  logic [2:0]  txd;
  logic [2:0]  busy;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Instance 0: no parity, 1 stop bit.
  axis_uart_tx #(.DIV_WIDTH(16), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .baud_div(baud_div),
    .s_axis_tvalid(tvalid[0]), .s_axis_tready(tready[0]),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
    .txd(txd[0]), .busy(busy[0]));

  // Instance 1: even parity, 2 stop bits.
  axis_uart_tx #(.DIV_WIDTH(16), .PARITY(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .baud_div(baud_div),
    .s_axis_tvalid(tvalid[1]), .s_axis_tready(tready[1]),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
    .txd(txd[1]), .busy(busy[1]));

  // Instance 2: odd parity, 1 stop bit.
  axis_uart_tx #(.DIV_WIDTH(16), .PARITY(2), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .baud_div(baud_div),
    .s_axis_tvalid(tvalid[2]), .s_axis_tready(tready[2]),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
    .txd(txd[2]), .busy(busy[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference frame: one entry per clk cycle, tready high only on the last one.
  task automatic push_frame(input logic [7:0] data, input int div, input int parity,
                            input int stop_bits);
    logic bits[$];
    int   d;
    d = (div == 0) ? 1 : div;
    bits.push_back(1'b0);
    for (int b = 0; b < 8; b++) bits.push_back(data[b]);
    if (parity == 1) bits.push_back(^data);
    if (parity == 2) bits.push_back(~^data);
    for (int s = 0; s < stop_bits; s++) bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < d; c++) begin
        exp_t e;
        e.txd    = bits[b];
        e.tready = (b == bits.size() - 1) && (c == d - 1);
        sb.push_back(e);
      end
    end
  endtask

  // Bounded wait for tready on one instance.
  task automatic wait_ready(input int inst);
    for (int i = 0; i < 500 && tready[inst] !== 1'b1; i++) step();
    check("wait_tready", tready[inst], 1'b1);
  endtask

  // Pop and compare n cycles of line activity.
  task automatic run_cycles(input int inst, input int n, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL %s_underrun observed=empty expected=entry", tag);
      end else begin
        e = sb.pop_front();
        check({tag, "_txd"}, txd[inst], e.txd);
        check({tag, "_busy"}, busy[inst], 1'b1);
        check({tag, "_tready"}, tready[inst], e.tready);
      end
      step();
    end
  endtask

  task automatic check_idle(input int inst, input string tag);
    check({tag, "_idle_txd"}, txd[inst], 1'b1);
    check({tag, "_idle_busy"}, busy[inst], 1'b0);
    check({tag, "_idle_tready"}, tready[inst], 1'b1);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  // Offer one kept byte, wait for acceptance, then play the whole frame.
  task automatic send_frame(input int inst, input logic [7:0] data, input int div,
                            input int parity, input int stop_bits, input string tag);
    int len;
    tdata           = data;
    tkeep           = 1'b1;
    baud_div        = 16'(div);
    tvalid[inst]    = 1'b1;
    wait_ready(inst);
    push_frame(data, div, parity, stop_bits);
    len = sb.size();
    step();
    tvalid[inst] = 1'b0;
    run_cycles(inst, len, tag);
    check_idle(inst, tag);
  endtask

  initial begin
    // Reset behaviour: tready low while rst is high, idle line afterwards.
    step();
    step();
    check("rst_tready", tready[0], 1'b0);
    check("rst_txd", txd[0], 1'b1);
    check("rst_busy", busy[0], 1'b0);
    rst = 1'b0;
    step();
    check_idle(0, "post_rst0");
    check_idle(1, "post_rst1");
    check_idle(2, "post_rst2");

    // tvalid low while ready: stays idle.
    step();
    step();
    check_idle(0, "no_valid");

    // 0x55 at div 4: 40-cycle frame of alternating bits.
    send_frame(0, 8'h55, 4, 0, 1, "f55");

    // Back-to-back 0xA3 then 0x0F with tvalid held high.
    tdata     = 8'hA3;
    tkeep     = 1'b1;
    baud_div  = 16'd4;
    tvalid[0] = 1'b1;
    wait_ready(0);
    push_frame(8'hA3, 4, 0, 1);
    step();
    tdata = 8'h0F;
    push_frame(8'h0F, 4, 0, 1);
    run_cycles(0, 40, "b2b_a3");
    tvalid[0] = 1'b0;
    run_cycles(0, 40, "b2b_0f");
    check_idle(0, "b2b");

    // Dropped beat (tkeep=0) then a kept beat.
    tdata     = 8'hFF;
    tkeep     = 1'b0;
    baud_div  = 16'd2;
    tvalid[0] = 1'b1;
    wait_ready(0);
    step();
    check("drop_txd", txd[0], 1'b1);
    check("drop_busy", busy[0], 1'b0);
    check("drop_tready", tready[0], 1'b1);
    tvalid[0] = 1'b0;
    send_frame(0, 8'h01, 2, 0, 1, "keep01");

    // Parity variants.
    send_frame(1, 8'h07, 3, 1, 2, "even07");
    send_frame(2, 8'h07, 3, 2, 1, "odd07");

    // Divisor 0 acts as 1; a mid-frame divisor change has no effect.
    tdata     = 8'h80;
    tkeep     = 1'b1;
    baud_div  = 16'd0;
    tvalid[0] = 1'b1;
    wait_ready(0);
    push_frame(8'h80, 0, 0, 1);
    step();
    tvalid[0] = 1'b0;
    run_cycles(0, 5, "div0_a");
    baud_div = 16'd8;
    run_cycles(0, 5, "div0_b");
    check_idle(0, "div0");

    // Reset in DATA bit 3 aborts the frame.
    tdata     = 8'h00;
    tkeep     = 1'b1;
    baud_div  = 16'd4;
    tvalid[0] = 1'b1;
    wait_ready(0);
    push_frame(8'h00, 4, 0, 1);
    step();
    tvalid[0] = 1'b0;
    run_cycles(0, 17, "abort");
    rst = 1'b1;
    check("abort_rst_tready", tready[0], 1'b0);
    step();
    check("abort_txd", txd[0], 1'b1);
    check("abort_tready_in_rst", tready[0], 1'b0);
    check("abort_busy_in_rst", busy[0], 1'b0);
    rst = 1'b0;
    sb.delete();
    step();
    check_idle(0, "abort");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
